// File: rtl/run_counter_bank.sv
// run_counter_bank: a bank of independent consecutive-run counters.
// Each channel counts back-to-back high cycles of its input up to MAX_RUN,
// then either wraps to zero or saturates. A one-cycle hit pulse marks entry
// into MAX_RUN, and a shared peak register tracks the largest count seen.
module run_counter_bank #(
    parameter int CHANNELS = 4,
    parameter int MAX_RUN  = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    en,
    input  logic                                    sat_mode,
    input  logic [CHANNELS-1:0]                     clr,
    input  logic                                    peak_clr,
    input  logic [CHANNELS-1:0]                     a,
    output logic [CHANNELS*$clog2(MAX_RUN+1)-1:0]   q,
    output logic [CHANNELS-1:0]                     hit,
    output logic [$clog2(MAX_RUN+1)-1:0]            peak
);

    localparam int            CW    = $clog2(MAX_RUN + 1);
    localparam logic [CW-1:0] MAX_Q = CW'(MAX_RUN);

    logic [CW-1:0]       cnt      [CHANNELS];
    logic [CW-1:0]       cnt_next [CHANNELS];
    logic [CHANNELS-1:0] hit_next;
    logic [CW-1:0]       max_next;

    // Next count per channel, the hit condition it implies, and the largest next count.
    // An out-of-range count (only reachable by forcing) always recovers to zero.
    always_comb begin
        hit_next = '0;
        max_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_next[i] = '0;
            if (clr[i] || (cnt[i] > MAX_Q)) begin
                cnt_next[i] = '0;
            end else if (!en) begin
                cnt_next[i] = cnt[i];
            end else if (!a[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] < MAX_Q) begin
                cnt_next[i] = cnt[i] + 1'b1;
            end else begin
                cnt_next[i] = sat_mode ? MAX_Q : '0;
            end
            hit_next[i] = (cnt_next[i] == MAX_Q) && (cnt[i] != MAX_Q);
            if (cnt_next[i] > max_next) begin
                max_next = cnt_next[i];
            end
        end
    end

    // Register counts, hit pulses and the peak tracker; peak_clr restarts from the new maximum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
            hit  <= '0;
            peak <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= cnt_next[i];
            end
            hit <= hit_next;
            if (peak_clr || (max_next > peak)) begin
                peak <= max_next;
            end
        end
    end

    // Pack the per-channel registers onto the output bus.
    always_comb begin
        q = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            q[i*CW +: CW] = cnt[i];
        end
    end

endmodule

// File: tb/tb_run_counter_bank.sv
// Testbench for run_counter_bank: a behavioural model compared every cycle,
// plus directed sequences with hand-computed expected counts, hits and peak.
module tb_run_counter_bank;

    localparam int CHANNELS = 4;
    localparam int MAX_RUN  = 4;
    localparam int CW       = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     en;
    logic                     sat_mode;
    logic [CHANNELS-1:0]      clr;
    logic                     peak_clr;
    logic [CHANNELS-1:0]      a;
    logic [CHANNELS*CW-1:0]   q;
    logic [CHANNELS-1:0]      hit;
    logic [CW-1:0]            peak;

    int checksTotal  = 0;
    int checksPassed = 0;

    // Model state: plain integers following the channel rules.
    int  mq [CHANNELS];
    int  mHit [CHANNELS];
    int  mPeak;
    bit  modelValid = 1'b0;

    int wrapQ [6] = '{1, 2, 3, 4, 0, 1};
    int satQ  [6] = '{1, 2, 3, 4, 4, 4};
    int runHit[6] = '{0, 0, 0, 1, 0, 0};
    int brkQ1 [5] = '{1, 2, 0, 1, 2};
    int brkQ2 [5] = '{1, 2, 3, 4, 0};
    int brkH2 [5] = '{0, 0, 0, 1, 0};
    logic [3:0] brkA [5] = '{4'b0110, 4'b0110, 4'b0100, 4'b0110, 4'b0110};

    run_counter_bank #(
        .CHANNELS (CHANNELS),
        .MAX_RUN  (MAX_RUN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sat_mode (sat_mode),
        .clr      (clr),
        .peak_clr (peak_clr),
        .a        (a),
        .q        (q),
        .hit      (hit),
        .peak     (peak)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checksTotal++;
        if (actual == expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkChan(input string name, input int ch, input int expQ, input int expHit);
        checkOutput({name, " q"}, int'(q[ch*CW +: CW]), expQ);
        checkOutput({name, " hit"}, int'(hit[ch]), expHit);
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic s,
                                 input logic [3:0] c, input logic p, input logic [3:0] av);
        rst_n    = r;
        en       = e;
        sat_mode = s;
        clr      = c;
        peak_clr = p;
        a        = av;
        @(posedge clk);
        #2;
    endtask

    // Model update on each rising edge, then compare the DUT against it shortly after.
    always @(posedge clk) begin
        int prev;
        int nxt;
        int mx;
        int packedQ;
        int packedHit;
        mx = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            prev = mq[i];
            if (!rst_n)                 nxt = 0;
            else if (clr[i])            nxt = 0;
            else if (!en)               nxt = prev;
            else if (!a[i])             nxt = 0;
            else if (prev < MAX_RUN)    nxt = prev + 1;
            else                        nxt = sat_mode ? MAX_RUN : 0;
            mHit[i] = (rst_n && nxt == MAX_RUN && prev != MAX_RUN) ? 1 : 0;
            mq[i]   = nxt;
            if (nxt > mx) mx = nxt;
        end
        if (!rst_n)         mPeak = 0;
        else if (peak_clr)  mPeak = mx;
        else if (mx > mPeak) mPeak = mx;
        if (!rst_n) modelValid = 1'b1;
        #1;
        if (modelValid) begin
            packedQ   = 0;
            packedHit = 0;
            for (int i = 0; i < CHANNELS; i++) begin
                packedQ   = packedQ | (mq[i] << (i * CW));
                packedHit = packedHit | (mHit[i] << i);
            end
            checkOutput("model q", int'(q), packedQ);
            checkOutput("model hit", int'(hit), packedHit);
            checkOutput("model peak", int'(peak), mPeak);
        end
    end

    initial begin
        for (int i = 0; i < CHANNELS; i++) begin
            mq[i]   = 0;
            mHit[i] = 0;
        end
        mPeak = 0;

        // Reset
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
        checkOutput("reset q", int'(q), 0);
        checkOutput("reset hit", int'(hit), 0);
        checkOutput("reset peak", int'(peak), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);

        // Wrap mode run on channel 0
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001);
            checkChan("wrap ch0", 0, wrapQ[k], runHit[k]);
        end
        checkOutput("wrap peak", int'(peak), 4);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);

        // Saturate mode run on channel 0
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0001);
            checkChan("sat ch0", 0, satQ[k], runHit[k]);
        end
        checkOutput("sat peak", int'(peak), 4);
        // Switch to wrap while held at MAX_RUN: next high cycle wraps
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001);
        checkChan("sat->wrap ch0", 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);

        // Break and channel independence
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, brkA[k]);
            checkChan("break ch1", 1, brkQ1[k], 0);
            checkChan("indep ch2", 2, brkQ2[k], brkH2[k]);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);

        // Enable hold and clear priority
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001);
        checkChan("pre-hold ch0", 0, 2, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0001);
            checkChan("hold ch0", 0, 2, 0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 4'b0001);
        checkChan("clear ch0", 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001);
        checkChan("after clear ch0", 0, 1, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);

        // Clear while entering MAX_RUN: no hit
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0010);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 4'b0010);
        checkChan("clear at max ch1", 1, 0, 0);

        // Peak tracking
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000);
        checkOutput("peak cleared", int'(peak), 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b1000);
        end
        checkOutput("peak run3", int'(peak), 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
        checkOutput("peak holds", int'(peak), 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0001);
        checkOutput("peak_clr with count", int'(peak), 1);

        // Reset mid-operation
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001);
        checkChan("pre-reset ch0", 0, 3, 0);
        checkOutput("pre-reset peak", int'(peak), 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001);
        checkOutput("mid reset q", int'(q), 0);
        checkOutput("mid reset hit", int'(hit), 0);
        checkOutput("mid reset peak", int'(peak), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001);
        checkChan("post reset ch0", 0, 1, 0);

        // Mixed deterministic traffic, checked by the model only
        for (int k = 0; k < 24; k++) begin
            applyStimulus(1'b1, (k % 5) != 0, k[3], ((k % 7) == 3) ? 4'b0010 : 4'b0000,
                          (k % 11) == 6, 4'((k * 7 + 3) | (k >> 2)));
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
